// File: rtl/c1_conv_sequencer.sv
// C1 layer sequencer: runs the 5x5 window generator once per output channel,
// feeding it the IFM through a 2-entry skid buffer and addressing OFM results.
module c1_conv_sequencer #(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int K      = 5,
    parameter int N_OFM  = 6,
    parameter int IFM_AW = 10,
    parameter int OFM_AW = 13
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic              i_abort,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic              o_ifm_rd_en,
    output logic [IFM_AW-1:0] o_ifm_rd_addr,
    input  logic [7:0]        i_ifm_rd_data,
    output logic              o_pix_valid,
    output logic [7:0]        o_pix,
    input  logic              i_pix_ready,
    output logic              o_lb_start,
    input  logic              i_lb_done,
    output logic [2:0]        o_wgt_sel,
    input  logic              i_res_valid,
    output logic              o_ofm_wr_en,
    output logic [OFM_AW-1:0] o_ofm_wr_addr
);
    localparam int OUT_W  = IMG_W - K + 1;
    localparam int OUT_H  = IMG_H - K + 1;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int OUT_SZ = OUT_W * OUT_H;

    localparam logic [IFM_AW:0]   NPIX_C    = (IFM_AW+1)'(NPIX);
    localparam logic [IFM_AW:0]   NPIX_LAST = (IFM_AW+1)'(NPIX - 1);
    localparam logic [IFM_AW:0]   CNT_ONE   = (IFM_AW+1)'(1);
    localparam logic [OFM_AW-1:0] OUT_SZ_C  = OFM_AW'(OUT_SZ);
    localparam logic [OFM_AW-1:0] RES_ONE   = OFM_AW'(1);
    localparam logic [2:0]        CH_LAST   = 3'(N_OFM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_STREAM,
        S_DRAIN,
        S_NEXT,
        S_FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        ch_q, ch_d;
    logic [OFM_AW-1:0] base_q, base_d;
    logic [IFM_AW:0]   rd_cnt_q, rd_cnt_d;
    logic [IFM_AW:0]   pop_cnt_q, pop_cnt_d;
    logic [OFM_AW-1:0] res_idx_q, res_idx_d;
    logic              err_q, err_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        occ_q, occ_d;
    logic [7:0]        buf0_q, buf0_d;
    logic [7:0]        buf1_q, buf1_d;

    logic              pix_valid;
    logic              pop;
    logic              rd_en;
    logic              in_res;
    logic [2:0]        fill;

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        base_d     = base_q;
        rd_cnt_d   = rd_cnt_q;
        pop_cnt_d  = pop_cnt_q;
        res_idx_d  = res_idx_q;
        err_d      = err_q;
        inflight_d = 1'b0;
        occ_d      = occ_q;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;

        o_done      = 1'b0;
        o_lb_start  = 1'b0;
        o_ofm_wr_en = 1'b0;

        pix_valid = (occ_q != 2'd0);
        pop       = pix_valid & i_pix_ready;
        // Occupancy the buffer will reach once the outstanding read lands.
        fill      = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        rd_en     = (state_q == S_STREAM) && (rd_cnt_q < NPIX_C) && (fill < 3'd2);
        in_res    = (state_q == S_STREAM) || (state_q == S_DRAIN);

        if (rd_en) begin
            rd_cnt_d = rd_cnt_q + CNT_ONE;
        end
        inflight_d = rd_en;
        if (pop) begin
            pop_cnt_d = pop_cnt_q + CNT_ONE;
        end

        if (inflight_q && !pop) begin
            if (occ_q == 2'd0) begin
                buf0_d = i_ifm_rd_data;
            end else begin
                buf1_d = i_ifm_rd_data;
            end
            occ_d = occ_q + 2'd1;
        end else if (!inflight_q && pop) begin
            buf0_d = buf1_q;
            occ_d  = occ_q - 2'd1;
        end else if (inflight_q && pop) begin
            if (occ_q == 2'd1) begin
                buf0_d = i_ifm_rd_data;
            end else begin
                buf0_d = buf1_q;
                buf1_d = i_ifm_rd_data;
            end
        end

        if (in_res && i_res_valid) begin
            if (res_idx_q < OUT_SZ_C) begin
                o_ofm_wr_en = 1'b1;
                res_idx_d   = res_idx_q + RES_ONE;
            end else begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_START;
                    ch_d    = 3'd0;
                    base_d  = '0;
                    err_d   = 1'b0;
                end
            end
            S_START: begin
                o_lb_start = 1'b1;
                rd_cnt_d   = '0;
                pop_cnt_d  = '0;
                res_idx_d  = '0;
                occ_d      = 2'd0;
                inflight_d = 1'b0;
                state_d    = S_STREAM;
            end
            S_STREAM: begin
                if (pop && (pop_cnt_q == NPIX_LAST)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (i_lb_done) begin
                    if (res_idx_q != OUT_SZ_C) begin
                        err_d = 1'b1;
                    end
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                // Channel index and OFM base only move here, so the weight bank is stable per channel.
                if (ch_q == CH_LAST) begin
                    state_d = S_FINISH;
                end else begin
                    ch_d    = ch_q + 3'd1;
                    base_d  = base_q + OUT_SZ_C;
                    state_d = S_START;
                end
            end
            S_FINISH: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if ((state_q != S_IDLE) && i_abort) begin
            state_d    = S_IDLE;
            occ_d      = 2'd0;
            inflight_d = 1'b0;
            err_d      = err_q;
            o_done     = 1'b0;
        end

        o_busy        = (state_q != S_IDLE);
        o_err         = err_q;
        o_ifm_rd_en   = rd_en;
        o_ifm_rd_addr = rd_cnt_q[IFM_AW-1:0];
        o_pix_valid   = pix_valid;
        o_pix         = buf0_q;
        o_wgt_sel     = ch_q;
        o_ofm_wr_addr = base_q + res_idx_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            ch_q       <= 3'd0;
            base_q     <= '0;
            rd_cnt_q   <= '0;
            pop_cnt_q  <= '0;
            res_idx_q  <= '0;
            err_q      <= 1'b0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            buf0_q     <= 8'd0;
            buf1_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            base_q     <= base_d;
            rd_cnt_q   <= rd_cnt_d;
            pop_cnt_q  <= pop_cnt_d;
            res_idx_q  <= res_idx_d;
            err_q      <= err_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

endmodule
